// File: rtl/ps2_key_scanner.sv
// ps2_key_scanner: PS/2 set-2 frame receiver and key decoder that injects the
// held key's ASCII code into the data RAM at the scan address.
module ps2_key_scanner #(
    parameter logic [12:0] SCAN_ADDR      = 13'h0310,
    parameter int          FILTER_LEN     = 4,
    parameter int          TIMEOUT_CYCLES = 50000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [12:0] key_ram_addr,
    output logic [31:0] key_ram_wdata,
    output logic        key_ram_wen,
    output logic [7:0]  last_scan
);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FW-1:0] FMAX = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0] S_IDLE = 2'd0, S_DATA = 2'd1, S_PARITY = 2'd2, S_STOP = 2'd3;

    logic [1:0]    r_clk_sync, r_dat_sync;
    logic          r_clk_filt, r_fall;
    logic [FW-1:0] r_filt_cnt;
    logic [1:0]    r_state;
    logic [2:0]    r_bit_cnt;
    logic [7:0]    r_shift, r_byte;
    logic          r_parity, r_byte_valid, r_frame_err;
    logic [TW-1:0] r_tmo_cnt;
    logic          r_brk, r_ext, r_shl, r_shr, r_wen;
    logic [7:0]    r_held, r_ascii, r_last;
    logic [7:0]    w_lc, w_ascii;
    logic          w_dat;

    assign w_dat         = r_dat_sync[1];
    assign key_ram_addr  = SCAN_ADDR;
    assign key_ram_wdata = {24'b0, r_ascii};
    assign key_ram_wen   = r_wen;
    assign last_scan     = r_last;

    // Sync flops idle high so reset release never looks like a falling edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_clk_sync <= 2'b11;
            r_dat_sync <= 2'b11;
            r_clk_filt <= 1'b1;
            r_filt_cnt <= '0;
            r_fall     <= 1'b0;
        end else begin
            r_clk_sync <= {r_clk_sync[0], ps2_clk};
            r_dat_sync <= {r_dat_sync[0], ps2_data};
            r_fall     <= r_clk_filt && !r_clk_sync[1] && r_filt_cnt == FMAX;
            if (r_clk_sync[1] == r_clk_filt) r_filt_cnt <= '0;
            else if (r_filt_cnt == FMAX) begin
                r_clk_filt <= r_clk_sync[1];
                r_filt_cnt <= '0;
            end else r_filt_cnt <= r_filt_cnt + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_parity     <= 1'b0;
            r_tmo_cnt    <= '0;
            r_byte_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            r_byte       <= '0;
        end else begin
            r_byte_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            if (r_fall) begin
                r_tmo_cnt <= '0;
                case (r_state)
                    S_IDLE: if (!w_dat) begin
                        r_state   <= S_DATA;
                        r_bit_cnt <= '0;
                    end
                    S_DATA: begin
                        r_shift   <= {w_dat, r_shift[7:1]};
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                        if (r_bit_cnt == 3'd7) r_state <= S_PARITY;
                    end
                    S_PARITY: begin
                        r_parity <= w_dat;
                        r_state  <= S_STOP;
                    end
                    default: begin
                        r_state <= S_IDLE;
                        if (^{r_shift, r_parity} && w_dat) begin
                            r_byte_valid <= 1'b1;
                            r_byte       <= r_shift;
                        end else r_frame_err <= 1'b1;
                    end
                endcase
            end else if (r_state != S_IDLE) begin
                if (r_tmo_cnt == TMAX) begin
                    r_state   <= S_IDLE;
                    r_tmo_cnt <= '0;
                end else r_tmo_cnt <= r_tmo_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        w_lc = 8'h00;
        case (r_byte)
            8'h1C: w_lc = 8'h61; 8'h32: w_lc = 8'h62; 8'h21: w_lc = 8'h63; 8'h23: w_lc = 8'h64;
            8'h24: w_lc = 8'h65; 8'h2B: w_lc = 8'h66; 8'h34: w_lc = 8'h67; 8'h33: w_lc = 8'h68;
            8'h43: w_lc = 8'h69; 8'h3B: w_lc = 8'h6A; 8'h42: w_lc = 8'h6B; 8'h4B: w_lc = 8'h6C;
            8'h3A: w_lc = 8'h6D; 8'h31: w_lc = 8'h6E; 8'h44: w_lc = 8'h6F; 8'h4D: w_lc = 8'h70;
            8'h15: w_lc = 8'h71; 8'h2D: w_lc = 8'h72; 8'h1B: w_lc = 8'h73; 8'h2C: w_lc = 8'h74;
            8'h3C: w_lc = 8'h75; 8'h2A: w_lc = 8'h76; 8'h1D: w_lc = 8'h77; 8'h22: w_lc = 8'h78;
            8'h35: w_lc = 8'h79; 8'h1A: w_lc = 8'h7A;
            8'h45: w_lc = 8'h30; 8'h16: w_lc = 8'h31; 8'h1E: w_lc = 8'h32; 8'h26: w_lc = 8'h33;
            8'h25: w_lc = 8'h34; 8'h2E: w_lc = 8'h35; 8'h36: w_lc = 8'h36; 8'h3D: w_lc = 8'h37;
            8'h3E: w_lc = 8'h38; 8'h46: w_lc = 8'h39;
            8'h29: w_lc = 8'h20; 8'h5A: w_lc = 8'h0D; 8'h66: w_lc = 8'h08;
            default: w_lc = 8'h00;
        endcase
        w_ascii = (w_lc >= 8'h61 && (r_shl || r_shr)) ? w_lc - 8'h20 : w_lc;
    end

    // A typematic repeat of the held code is swallowed so shift changes never leak in.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_brk   <= 1'b0;
            r_ext   <= 1'b0;
            r_shl   <= 1'b0;
            r_shr   <= 1'b0;
            r_wen   <= 1'b0;
            r_held  <= '0;
            r_ascii <= '0;
            r_last  <= '0;
        end else if (r_frame_err) begin
            r_brk <= 1'b0;
            r_ext <= 1'b0;
        end else if (r_byte_valid) begin
            r_last <= r_byte;
            if (r_byte == 8'hF0) r_brk <= 1'b1;
            else if (r_byte == 8'hE0) r_ext <= 1'b1;
            else if (r_ext) begin
                r_ext <= 1'b0;
                r_brk <= 1'b0;
            end else begin
                r_brk <= 1'b0;
                if (r_byte == 8'h12) r_shl <= !r_brk;
                else if (r_byte == 8'h59) r_shr <= !r_brk;
                else if (r_brk) begin
                    if (r_byte == r_held) begin
                        r_held  <= '0;
                        r_ascii <= '0;
                        r_wen   <= 1'b0;
                    end
                end else if (w_lc != 8'h00 && r_byte != r_held) begin
                    r_held  <= r_byte;
                    r_ascii <= w_ascii;
                    r_wen   <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_ps2_key_scanner.sv
// tb_ps2_key_scanner: drives PS/2 frames at the pins and checks the RAM
// injection outputs against expectations queued alongside each frame.
module tb_ps2_key_scanner;
    localparam int HALF = 40;
    typedef struct packed {logic wen; logic [31:0] wdata; logic [7:0] last;} exp_t;
    typedef struct packed {logic [7:0] code; logic good; exp_t e;} step_t;

    logic        clk = 1'b0, rst_n = 1'b0, ps2_clk = 1'b1, ps2_data = 1'b1;
    logic [12:0] key_ram_addr;
    logic [31:0] key_ram_wdata;
    logic        key_ram_wen;
    logic [7:0]  last_scan;
    int          checks = 0, failures = 0;
    exp_t        sb[$];

    always #5 clk = ~clk;

    ps2_key_scanner #(.SCAN_ADDR(13'h0310), .FILTER_LEN(4), .TIMEOUT_CYCLES(400)) dut (
        .clock(clk), .reset(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .key_ram_addr(key_ram_addr), .key_ram_wdata(key_ram_wdata),
        .key_ram_wen(key_ram_wen), .last_scan(last_scan)
    );

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic ps2_bit(input logic b);
        ps2_data = b;
        idle(HALF);
        ps2_clk = 1'b0;
        idle(HALF);
        ps2_clk = 1'b1;
    endtask

    task automatic send_raw(input logic [7:0] b, input logic good, input int nbits);
        logic [10:0] f;
        f = {1'b1, good ? ~^b : ^b, b, 1'b0};
        for (int i = 0; i < nbits; i++) ps2_bit(f[i]);
        ps2_data = 1'b1;
    endtask

    task automatic drive_step(input step_t s);
        sb.push_back(s.e);
        send_raw(s.code, s.good, 11);
        idle(20);
        #1;
    endtask

    task automatic test_reset();
        idle(5);
        #1;
        checks++;
        if ({key_ram_wen, key_ram_wdata, last_scan} !== 41'd0) begin
            failures++;
            $display("FAIL reset_outputs got wen=%b wdata=%h last=%h exp all zero", key_ram_wen, key_ram_wdata, last_scan);
        end
        checks++;
        if (key_ram_addr !== 13'h0310) begin
            failures++;
            $display("FAIL reset_addr got %h exp 0310", key_ram_addr);
        end
        @(negedge clk) rst_n = 1'b1;
        idle(10);
    endtask

    task automatic test_basic();
        step_t s[3] = '{{8'h1C, 1'b1, 1'b1, 32'h61, 8'h1C},
                        {8'hF0, 1'b1, 1'b1, 32'h61, 8'hF0},
                        {8'h1C, 1'b1, 1'b0, 32'h00, 8'h1C}};
        exp_t e, g;
        foreach (s[i]) begin
            drive_step(s[i]);
            e = sb.pop_front();
            g = {key_ram_wen, key_ram_wdata, last_scan};
            checks++;
            if (g !== e) begin
                failures++;
                $display("FAIL basic[%0d] got wen=%b wdata=%h last=%h exp wen=%b wdata=%h last=%h", i, g.wen, g.wdata, g.last, e.wen, e.wdata, e.last);
            end
        end
    endtask

    task automatic test_shift();
        step_t s[9] = '{{8'h12, 1'b1, 1'b0, 32'h00, 8'h12},
                        {8'h1C, 1'b1, 1'b1, 32'h41, 8'h1C},
                        {8'hF0, 1'b1, 1'b1, 32'h41, 8'hF0},
                        {8'h1C, 1'b1, 1'b0, 32'h00, 8'h1C},
                        {8'hF0, 1'b1, 1'b0, 32'h00, 8'hF0},
                        {8'h12, 1'b1, 1'b0, 32'h00, 8'h12},
                        {8'h1C, 1'b1, 1'b1, 32'h61, 8'h1C},
                        {8'hF0, 1'b1, 1'b1, 32'h61, 8'hF0},
                        {8'h1C, 1'b1, 1'b0, 32'h00, 8'h1C}};
        exp_t e, g;
        foreach (s[i]) begin
            drive_step(s[i]);
            e = sb.pop_front();
            g = {key_ram_wen, key_ram_wdata, last_scan};
            checks++;
            if (g !== e) begin
                failures++;
                $display("FAIL shift[%0d] got wen=%b wdata=%h last=%h exp wen=%b wdata=%h last=%h", i, g.wen, g.wdata, g.last, e.wen, e.wdata, e.last);
            end
        end
    endtask

    task automatic test_back_to_back();
        step_t s[5] = '{{8'h16, 1'b1, 1'b1, 32'h31, 8'h16},
                        {8'h1E, 1'b1, 1'b1, 32'h32, 8'h1E},
                        {8'h1E, 1'b1, 1'b1, 32'h32, 8'h1E},
                        {8'hF0, 1'b1, 1'b1, 32'h32, 8'hF0},
                        {8'h16, 1'b1, 1'b1, 32'h32, 8'h16}};
        exp_t e, g;
        foreach (s[i]) begin
            drive_step(s[i]);
            e = sb.pop_front();
            g = {key_ram_wen, key_ram_wdata, last_scan};
            checks++;
            if (g !== e) begin
                failures++;
                $display("FAIL b2b[%0d] got wen=%b wdata=%h last=%h exp wen=%b wdata=%h last=%h", i, g.wen, g.wdata, g.last, e.wen, e.wdata, e.last);
            end
        end
    endtask

    task automatic test_parity();
        step_t s[2] = '{{8'h1C, 1'b0, 1'b1, 32'h32, 8'h16},
                        {8'h29, 1'b1, 1'b1, 32'h20, 8'h29}};
        exp_t e, g;
        foreach (s[i]) begin
            drive_step(s[i]);
            e = sb.pop_front();
            g = {key_ram_wen, key_ram_wdata, last_scan};
            checks++;
            if (g !== e) begin
                failures++;
                $display("FAIL parity[%0d] got wen=%b wdata=%h last=%h exp wen=%b wdata=%h last=%h", i, g.wen, g.wdata, g.last, e.wen, e.wdata, e.last);
            end
        end
    endtask

    task automatic test_timeout();
        step_t s[3] = '{{8'h5A, 1'b1, 1'b1, 32'h0D, 8'h5A},
                        {8'hE0, 1'b1, 1'b1, 32'h0D, 8'hE0},
                        {8'h75, 1'b1, 1'b1, 32'h0D, 8'h75}};
        exp_t e, g;
        send_raw(8'h1C, 1'b1, 5);
        idle(600);
        foreach (s[i]) begin
            drive_step(s[i]);
            e = sb.pop_front();
            g = {key_ram_wen, key_ram_wdata, last_scan};
            checks++;
            if (g !== e) begin
                failures++;
                $display("FAIL timeout[%0d] got wen=%b wdata=%h last=%h exp wen=%b wdata=%h last=%h", i, g.wen, g.wdata, g.last, e.wen, e.wdata, e.last);
            end
        end
    endtask

    task automatic test_mid_reset();
        step_t s[2] = '{{8'h1C, 1'b1, 1'b1, 32'h61, 8'h1C},
                        {8'h66, 1'b1, 1'b1, 32'h08, 8'h66}};
        exp_t e, g;
        drive_step(s[0]);
        e = sb.pop_front();
        g = {key_ram_wen, key_ram_wdata, last_scan};
        checks++;
        if (g !== e) begin
            failures++;
            $display("FAIL mid_reset_pre got wen=%b wdata=%h last=%h exp wen=%b wdata=%h last=%h", g.wen, g.wdata, g.last, e.wen, e.wdata, e.last);
        end
        send_raw(8'h66, 1'b1, 5);
        #2 rst_n = 1'b0;
        sb.push_back('0);
        #1;
        e = sb.pop_front();
        g = {key_ram_wen, key_ram_wdata, last_scan};
        checks++;
        if (g !== e) begin
            failures++;
            $display("FAIL mid_reset_async got wen=%b wdata=%h last=%h exp all zero", g.wen, g.wdata, g.last);
        end
        idle(5);
        @(negedge clk) rst_n = 1'b1;
        idle(10);
        drive_step(s[1]);
        e = sb.pop_front();
        g = {key_ram_wen, key_ram_wdata, last_scan};
        checks++;
        if (g !== e) begin
            failures++;
            $display("FAIL mid_reset_post got wen=%b wdata=%h last=%h exp wen=%b wdata=%h last=%h", g.wen, g.wdata, g.last, e.wen, e.wdata, e.last);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_shift();
        test_back_to_back();
        test_parity();
        test_timeout();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
